// File: rtl/ram_master_pkg.sv
// Shared definitions for the RAM burst master: command opcodes, FSM states
// and default address/data widths.
package ram_master_pkg;

    localparam int unsigned DefaultAddrW = 8;
    localparam int unsigned DefaultDataW = 8;
    localparam int unsigned LenW         = 8;

    typedef enum logic [1:0] {
        OpWrite   = 2'b00,
        OpRead    = 2'b01,
        OpFill    = 2'b10,
        OpIllegal = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StFill
    } state_e;

endpackage

// File: rtl/ram_rd_buf.sv
// Single-entry read output register: holds one RAM read beat plus its
// last flag until the consumer takes it with rdata_ready.
module ram_rd_buf
    import ram_master_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              can_load,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last
);

    logic              valid_q;
    logic              last_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            last_q  <= load_last;
            data_q  <= load_data;
        end else if (rdata_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    // A new beat may enter while the current one is being drained.
    assign can_load    = !valid_q || rdata_ready;
    assign rdata_valid = valid_q;
    assign rdata       = data_q;
    assign rdata_last  = last_q;

endmodule

// File: rtl/ram_burst_master.sv
// Command-driven burst master for a single-port RAM (write, read, fill).
// The fill op is compiled in only when RAM_BURST_MASTER_FILL_EN is defined.
module ram_burst_master
    import ram_master_pkg::*;
#(
    parameter int unsigned ADDR_W = DefaultAddrW,
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LenW-1:0]   cmd_len,
    input  logic [DATA_W-1:0] cmd_fill_val,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              rd_ram,
    output logic              wr_ram,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] data_in_ram,
    input  logic [DATA_W-1:0] data_out_ram,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LenW-1:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              beat;
    logic              last_beat;
    logic              buf_load;
    logic              buf_can_load;
    op_e               op;

    assign op        = op_e'(cmd_op);
    assign last_beat = (cnt_q == '0);

`ifdef RAM_BURST_MASTER_FILL_EN
    logic [DATA_W-1:0] fill_q, fill_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end
`else
    logic unused_fill_val;
    assign unused_fill_val = ^cmd_fill_val;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        beat        = 1'b0;
        buf_load    = 1'b0;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        rd_ram      = 1'b0;
        wr_ram      = 1'b0;
        ram_addr    = '0;
        data_in_ram = '0;
`ifdef RAM_BURST_MASTER_FILL_EN
        fill_d      = fill_q;
`endif

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    cnt_d  = cmd_len;
                    case (op)
                        OpWrite: state_d = StWrite;
                        OpRead:  state_d = StRead;
`ifdef RAM_BURST_MASTER_FILL_EN
                        OpFill: begin
                            state_d = StFill;
                            fill_d  = cmd_fill_val;
                        end
`endif
                        // Illegal (and fill when not built in): pulse err, stay idle.
                        default: err_d = 1'b1;
                    endcase
                end
            end
            StWrite: begin
                wdata_ready = 1'b1;
                wr_ram      = wdata_valid;
                ram_addr    = addr_q;
                data_in_ram = wdata;
                beat        = wdata_valid;
            end
            StRead: begin
                rd_ram   = buf_can_load;
                ram_addr = addr_q;
                buf_load = buf_can_load;
                beat     = buf_can_load;
            end
`ifdef RAM_BURST_MASTER_FILL_EN
            StFill: begin
                wr_ram      = 1'b1;
                ram_addr    = addr_q;
                data_in_ram = fill_q;
                beat        = 1'b1;
            end
`endif
            default: state_d = StIdle;
        endcase

        // Address wraps naturally at the top of the RAM.
        if (beat) begin
            if (last_beat) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q - LenW'(1);
            end
        end
    end

    ram_rd_buf #(
        .DATA_W(DATA_W)
    ) u_rd_buf (
        .clock       (clock),
        .reset_n     (reset_n),
        .load        (buf_load),
        .load_data   (data_out_ram),
        .load_last   (last_beat),
        .can_load    (buf_can_load),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .rdata_last  (rdata_last)
    );

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: doc/ram_burst_master.md
RAM_BURST_MASTER -- requirements
Module: ram_burst_master

Interface
REQ-001 Parameters SHALL be: ADDR_W, 8, RAM address width; DATA_W, 8, RAM data width.
REQ-002 clock  input  1  sole clock, all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-005 cmd_op  input  2  00 write burst, 01 read burst, 10 fill, 11 illegal.
REQ-006 cmd_addr / cmd_len  input  ADDR_W / 8  start address; beat count minus one (1..256 beats).
REQ-007 cmd_fill_val  input  DATA_W  fill pattern.
REQ-008 wdata_valid / wdata_ready / wdata  input / output / input  1 / 1 / DATA_W  write-data stream.
REQ-009 rdata_valid / rdata_ready / rdata / rdata_last  output / input / output / output  1 / 1 / DATA_W / 1  read-data stream.
REQ-010 rd_ram / wr_ram / ram_addr / data_in_ram  output  1 / 1 / ADDR_W / DATA_W  RAM strobes, address, write data.
REQ-011 data_out_ram  input  DATA_W  RAM combinational read data, valid only while rd_ram=1.
REQ-012 busy / done / err  output  1 / 1 / 1  op in progress; one-cycle completion pulse; one-cycle illegal-op pulse.

Function
REQ-013 FSM states SHALL be IDLE, WRITE, READ, FILL; cmd_ready=1 only in IDLE; busy=1 in all other states.
REQ-014 On accept, SHALL latch cmd_addr into the current-address counter and cmd_len into the remaining-beat counter, then enter the state for cmd_op on the next edge.
REQ-015 WRITE: wdata_ready=1; wr_ram=wdata_valid; ram_addr=current address; data_in_ram=wdata; each accepted beat increments address and decrements count.
REQ-016 READ: rd_ram=1 when the output register is empty or being drained (!rdata_valid || rdata_ready); data_out_ram SHALL be captured into rdata on that edge, giving rdata_valid one cycle later; sustained throughput is 1 beat/cycle.
REQ-017 rdata_last SHALL be 1 with the final beat of a read burst only.
REQ-018 FILL: wr_ram=1 every cycle with data_in_ram=cmd_fill_val latched at accept; no stall possible.
REQ-019 Address SHALL wrap 255->0 within a burst without error.
REQ-020 rd_ram and wr_ram SHALL never be 1 simultaneously; both SHALL be 0 in IDLE.
REQ-021 After the final RAM access, the FSM SHALL return to IDLE and pulse done for one cycle on the next edge.
REQ-022 A new command MAY be accepted while a last rdata beat is still pending; the next READ SHALL stall on the occupied register per REQ-016.
REQ-023 cmd_op=11 SHALL be accepted, pulse err for one cycle, issue no RAM access, and remain in IDLE.

Reset
REQ-024 reset_n=0 SHALL immediately force IDLE, cmd_ready=1 after release, and all other outputs 0, with counters 0.
REQ-025 Reset mid-burst SHALL abort the burst; RAM contents already written SHALL remain; no done pulse SHALL be issued.

Configuration
REQ-026 Macro RAM_BURST_MASTER_FILL_EN SHALL compile in the FILL state and fill datapath.
REQ-027 Without RAM_BURST_MASTER_FILL_EN, cmd_op=10 SHALL be handled exactly as cmd_op=11 (per REQ-023), and cmd_fill_val SHALL be ignored.

Structure
REQ-028 Package ram_master_pkg SHALL hold op encodings, the FSM state type, and the ADDR_W/DATA_W defaults.
REQ-029 Sub-module ram_rd_buf SHALL implement the single-entry read output register with valid/ready and last flag.

Verification
REQ-030 Write addr=0x10 len=3 with data A0..A3 -> wr_ram high 4 cycles at 0x10..0x13, done pulse once, then busy=0.
REQ-031 Read addr=0x10 len=3, rdata_ready=1 -> rdata A0,A1,A2,A3 on consecutive cycles, rdata_last only on A3.
REQ-032 Read addr=0xFE len=3 with rdata_ready toggling 1/0 -> addresses 0xFE,0xFF,0x00,0x01; no beat lost or duplicated.
REQ-033 Fill addr=0x80 len=255 val=0x5A -> 256 consecutive writes; RAM reads back 0x5A everywhere; without macro -> err pulse, no writes.
REQ-034 cmd_op=11 -> err pulse, no rd_ram/wr_ram; reset_n low during the 3rd beat of an 8-beat write -> outputs 0 at once, first 2 or 3 locations written, no done pulse.
